// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// The hazard ports on the top level exist only when WB_HAZ_EN is defined.
package wb_pkg;

    localparam int NREQ  = 3;
    localparam int WB_DW = 32;
    localparam int WB_AW = 4;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_BASE = 2;

    localparam logic [WB_AW-1:0] REG_PC = 4'd15;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic             valid;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef logic [1:0] req_idx_t;

    // Requester index successor, wrapping modulo NREQ.
    function automatic req_idx_t next_idx(input req_idx_t i);
        return (i == req_idx_t'(NREQ - 1)) ? '0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding slot for a single write-back producer.
// Handshake: a request is taken on an edge where accept_i is high (valid & ready).
module wb_slot
    import wb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             accept_i,
    input  logic             grant_i,
    input  logic [WB_AW-1:0] addr_i,
    input  logic [WB_DW-1:0] data_i,
    output logic             full_o,
    output logic             ready_o,
    output wb_entry_t        entry_o
);

    slot_state_e state_q, state_d;
    wb_entry_t   entry_q, entry_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // An accept on the grant edge replaces the issuing entry, so no bubble appears.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (accept_i) begin
            state_d       = SLOT_FULL;
            entry_d.valid = 1'b1;
            entry_d.addr  = addr_i;
            entry_d.data  = data_i;
        end else if (grant_i) begin
            state_d       = SLOT_EMPTY;
            entry_d.valid = 1'b0;
        end
    end

    assign full_o  = (state_q == SLOT_FULL);
    assign ready_o = (state_q == SLOT_EMPTY) | grant_i;
    assign entry_o = entry_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin scheduler sharing the register file write port among ALU, MEM and BASE.
// Define WB_HAZ_EN to add read-address hazard outputs (A/B in, HzA/HzB out).
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NREQ-1:0]   ReqV,
    output logic [NREQ-1:0]   ReqR,
    input  logic [NREQ*AW-1:0] ReqA,
    input  logic [NREQ*DW-1:0] ReqD,
    output logic [AW-1:0]     C,
    output logic [DW-1:0]     PC,
    output logic              RF,
    output logic              PcWr,
    output logic              Busy
`ifdef WB_HAZ_EN
    ,
    input  logic [AW-1:0]     A,
    input  logic [AW-1:0]     B,
    output logic              HzA,
    output logic              HzB
`endif
);

    logic [NREQ-1:0] slot_full;
    logic [NREQ-1:0] slot_ready;
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] grant;
    wb_entry_t       slot_entry [NREQ];

    req_idx_t  ptr_q, ptr_d;
    req_idx_t  arb_idx;
    req_idx_t  grant_idx;
    logic      grant_any;
    wb_entry_t win;

    logic          rf_q, rf_d;
    logic          pcwr_q, pcwr_d;
    logic [AW-1:0] c_q, c_d;
    logic [DW-1:0] pc_q, pc_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign accept[i] = ReqV[i] & slot_ready[i];

        wb_slot u_slot (
            .clk_i    (Clk),
            .rst_ni   (Rst_n),
            .accept_i (accept[i]),
            .grant_i  (grant[i]),
            .addr_i   (ReqA[i*AW +: AW]),
            .data_i   (ReqD[i*DW +: DW]),
            .full_o   (slot_full[i]),
            .ready_o  (slot_ready[i]),
            .entry_o  (slot_entry[i])
        );
    end

    assign ReqR = slot_ready;

    // Search order is ptr, ptr+1, ptr+2; the first full slot wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_q;
        arb_idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && slot_full[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = arb_idx;
            end
            arb_idx = next_idx(arb_idx);
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_any && (grant_idx == req_idx_t'(i));
        end
    end

    assign win   = slot_entry[grant_idx];
    assign ptr_d = grant_any ? next_idx(grant_idx) : ptr_q;

    // Write-port stage: address and data hold their last value when idle.
    always_comb begin
        rf_d   = grant_any & win.valid;
        pcwr_d = grant_any & win.valid & (win.addr == REG_PC);
        c_d    = c_q;
        pc_d   = pc_q;
        if (grant_any) begin
            c_d  = win.addr;
            pc_d = win.data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q  <= '0;
            rf_q   <= 1'b0;
            pcwr_q <= 1'b0;
            c_q    <= '0;
            pc_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rf_q   <= rf_d;
            pcwr_q <= pcwr_d;
            c_q    <= c_d;
            pc_q   <= pc_d;
        end
    end

    assign RF   = rf_q;
    assign PcWr = pcwr_q;
    assign C    = c_q;
    assign PC   = pc_q;
    assign Busy = (|slot_full) | rf_q;

`ifdef WB_HAZ_EN
    // A write is pending while it sits in a slot or in the write-port stage.
    always_comb begin
        HzA = rf_q && (c_q == A);
        HzB = rf_q && (c_q == B);
        for (int i = 0; i < NREQ; i++) begin
            if (slot_full[i] && (slot_entry[i].addr == A)) HzA = 1'b1;
            if (slot_full[i] && (slot_entry[i].addr == B)) HzB = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; hazard checks compile in with WB_HAZ_EN.
// Expected writes are queued at stimulus time and popped whenever RF is seen high.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int EW = 1 + AW + DW;

  logic             Clk;
  logic             Rst_n;
  logic [NR-1:0]    ReqV;
  logic [NR-1:0]    ReqR;
  logic [NR*AW-1:0] ReqA;
  logic [NR*DW-1:0] ReqD;
  logic [AW-1:0]    C;
  logic [DW-1:0]    PC;
  logic             RF;
  logic             PcWr;
  logic             Busy;
`ifdef WB_HAZ_EN
  logic [AW-1:0]    A;
  logic [AW-1:0]    B;
  logic             HzA;
  logic             HzB;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .ReqV (ReqV),
    .ReqR (ReqR),
    .ReqA (ReqA),
    .ReqD (ReqD),
    .C    (C),
    .PC   (PC),
    .RF   (RF),
    .PcWr (PcWr),
    .Busy (Busy)
`ifdef WB_HAZ_EN
    ,
    .A    (A),
    .B    (B),
    .HzA  (HzA),
    .HzB  (HzB)
`endif
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic pcwr);
    exp_q.push_back({pcwr, addr, data});
  endtask

  // Hold the request through one rising edge, then drop valid.
  task automatic send(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    ReqV = v;
    ReqA = a;
    ReqD = d;
    @(posedge Clk);
    #1;
    ReqV = '0;
  endtask

  // scoreboard: every RF strobe must match the oldest expected write
  always @(negedge Clk) begin
    if (Rst_n && RF) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", 32'(RF), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(C), 32'(e[DW+AW-1:DW]));
        check_eq("wr_data", PC, e[DW-1:0]);
        check_eq("wr_pcwr", 32'(PcWr), 32'(e[EW-1]));
      end
    end
  end

  initial begin
    Rst_n = 1'b0;
    ReqV  = '0;
    ReqA  = '0;
    ReqD  = '0;
`ifdef WB_HAZ_EN
    A = '0;
    B = '0;
`endif
    #12;
    check_eq("rst_rf", 32'(RF), 32'd0);
    check_eq("rst_pcwr", 32'(PcWr), 32'd0);
    check_eq("rst_c", 32'(C), 32'd0);
    check_eq("rst_pc", PC, 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check_eq("rst_ready", 32'(ReqR), 32'h7);

    // single ALU write: RF the cycle after the edge following acceptance
    push_exp(4'd3, 32'hDEADBEEF, 1'b0);
    send(3'b001, {4'd0, 4'd0, 4'd3}, {32'd0, 32'd0, 32'hDEADBEEF});
    @(negedge Clk);
    check_eq("lat_rf0", 32'(RF), 32'd0);
    check_eq("lat_busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    check_eq("lat_rf1", 32'(RF), 32'd1);
    @(negedge Clk);
    check_eq("lat_rf2", 32'(RF), 32'd0);
    check_eq("idle_busy", 32'(Busy), 32'd0);

    // three-way contention with ptr at MEM after the ALU grant
    push_exp(4'd2, 32'h22, 1'b0);
    push_exp(4'd3, 32'h33, 1'b0);
    push_exp(4'd1, 32'h11, 1'b0);
    send(3'b111, {4'd3, 4'd2, 4'd1}, {32'h33, 32'h22, 32'h11});
    @(negedge Clk);
    check_eq("cont_ready0", 32'(ReqR), 32'h2);
    @(negedge Clk);
    check_eq("cont_ready1", 32'(ReqR), 32'h6);
    @(negedge Clk);
    check_eq("cont_ready2", 32'(ReqR), 32'h7);
    repeat (3) @(negedge Clk);

    // back-to-back ALU stream
    for (int i = 0; i < 8; i++) begin
      ReqV = 3'b001;
      ReqA = {4'd0, 4'd0, 4'd7};
      ReqD = {64'd0, 32'(i)};
      push_exp(4'd7, 32'(i), 1'b0);
      check_eq("stream_ready", 32'(ReqR[0]), 32'd1);
      if (i >= 2) check_eq("stream_rf", 32'(RF), 32'd1);
      @(negedge Clk);
    end
    ReqV = '0;
    check_eq("stream_rf_tail", 32'(RF), 32'd1);
    repeat (3) @(negedge Clk);

    // MEM write to R15 raises PcWr alongside RF
    push_exp(4'd15, 32'h00000100, 1'b1);
    send(3'b010, {4'd0, 4'd15, 4'd0}, {32'd0, 32'h00000100, 32'd0});
    repeat (2) @(negedge Clk);
    check_eq("pc_pcwr", 32'(PcWr), 32'd1);
    @(negedge Clk);
    check_eq("pc_pcwr_off", 32'(PcWr), 32'd0);

    // reset while a write is in the output stage and two slots still hold entries
    send(3'b111, {4'd3, 4'd2, 4'd1}, {32'hA3, 32'hA2, 32'hA1});
    @(posedge Clk);
    #2;
    check_eq("pre_rst_rf", 32'(RF), 32'd1);
    Rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rf", 32'(RF), 32'd0);
    check_eq("mid_rst_busy", 32'(Busy), 32'd0);
    check_eq("mid_rst_c", 32'(C), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    check_eq("post_rst_busy", 32'(Busy), 32'd0);
    check_eq("post_rst_ready", 32'(ReqR), 32'h7);

    // contention order after reset proves ptr returned to ALU
    push_exp(4'd1, 32'h51, 1'b0);
    push_exp(4'd2, 32'h52, 1'b0);
    push_exp(4'd3, 32'h53, 1'b0);
    send(3'b111, {4'd3, 4'd2, 4'd1}, {32'h53, 32'h52, 32'h51});
    @(negedge Clk);
    check_eq("rst_cont_ready", 32'(ReqR), 32'h1);
    repeat (4) @(negedge Clk);

`ifdef WB_HAZ_EN
    // BASE holds R5 behind ALU and MEM; HzA stays up until it leaves the output stage
    A = 4'd5;
    B = 4'd6;
    push_exp(4'd1, 32'h61, 1'b0);
    push_exp(4'd2, 32'h62, 1'b0);
    push_exp(4'd5, 32'h65, 1'b0);
    send(3'b111, {4'd5, 4'd2, 4'd1}, {32'h65, 32'h62, 32'h61});
    for (int j = 0; j < 5; j++) begin
      @(negedge Clk);
      check_eq("haz_a", 32'(HzA), (j < 4) ? 32'd1 : 32'd0);
      check_eq("haz_b", 32'(HzB), 32'd0);
    end
`endif

    repeat (3) @(negedge Clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
